// File: rtl/vrb_pkg.sv
// vrb_pkg: shared types and constants for the VRB master arbiter.
//   vrb_arb_state_e   arbiter state (idle / one transaction outstanding)
//   vrb_idx_w()       grant index width for a given master count, minimum 1 bit
//   VRB_TO_CYCLES_DEF default watchdog limit
package vrb_pkg;

   typedef enum logic {
      VRB_ARB_IDLE = 1'b0,
      VRB_ARB_BUSY = 1'b1
   } vrb_arb_state_e;

   localparam int unsigned VRB_IDX_W_MIN     = 1;
   localparam int unsigned VRB_TO_CYCLES_DEF = 255;

   // $clog2(1) is 0, which would give a zero-width index.
   function automatic int unsigned vrb_idx_w(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < VRB_IDX_W_MIN) ? VRB_IDX_W_MIN : w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   request vector, one bit per master
//   ptr   index of the last granted master; search starts at (ptr+1) mod NM
//   grant one-hot grant (all zero when nothing requests)
//   idx   index of the granted master
//   any   at least one request present
module rr_pick
   import vrb_pkg::*;
#(
   parameter int unsigned NM = 2,
   parameter int unsigned IW = vrb_idx_w(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [NM-1:0] grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int unsigned start;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      start = (32'(ptr) + 1) % NM;
      for (int unsigned i = 0; i < NM; i++) begin
         int unsigned k;
         k = (start + i) % NM;
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = IW'(k);
         end
      end
   end

endmodule

// File: rtl/vrb_arbiter.sv
// vrb_arbiter: shares one VRB slave port between NM masters with round-robin
// grant and at most one outstanding transaction; responses return to the
// master that issued the command.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_m_cmd_*         per-master command (valid/addr/read/wdata/wmask), packed by master
//   o_m_cmd_ready     one-hot command accept
//   o_m_rsp_valid     one-hot response strobe for the owning master
//   o_m_rsp_err/rdata shared response error / read data
//   o_s_cmd_*         command towards the slave
//   i_s_rsp_*         response from the slave
//   o_busy            a transaction is outstanding
//
// Build option: define VRB_ARB_TIMEOUT_EN to add a watchdog that answers with an
// error response after TO_CYCLES silent BUSY cycles. Without it BUSY waits forever.
module vrb_arbiter
   import vrb_pkg::*;
#(
   parameter int unsigned NM        = 2,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned TO_CYCLES = VRB_TO_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NM-1:0]        i_m_cmd_valid,
   input  logic [NM*AW-1:0]     i_m_cmd_addr,
   input  logic [NM-1:0]        i_m_cmd_read,
   input  logic [NM*DW-1:0]     i_m_cmd_wdata,
   input  logic [NM*DW/8-1:0]   i_m_cmd_wmask,
   output logic [NM-1:0]        o_m_cmd_ready,
   output logic [NM-1:0]        o_m_rsp_valid,
   output logic                 o_m_rsp_err,
   output logic [DW-1:0]        o_m_rsp_rdata,
   output logic                 o_s_cmd_valid,
   output logic [AW-1:0]        o_s_cmd_addr,
   output logic                 o_s_cmd_read,
   output logic [DW-1:0]        o_s_cmd_wdata,
   output logic [DW/8-1:0]      o_s_cmd_wmask,
   input  logic                 i_s_rsp_valid,
   input  logic                 i_s_rsp_err,
   input  logic [DW-1:0]        i_s_rsp_rdata,
   output logic                 o_busy
);

   localparam int unsigned IW = vrb_idx_w(NM);
   localparam int unsigned MW = DW / 8;

   vrb_arb_state_e state_q, state_d;
   logic [IW-1:0]  owner_q, owner_d;
   logic [IW-1:0]  last_q, last_d;

   logic [NM-1:0]  pick_oh;
   logic [IW-1:0]  pick_idx;
   logic           pick_any;
   logic           accept;
   logic           timeout;
   logic [NM-1:0]  owner_oh;

   rr_pick #(
      .NM (NM),
      .IW (IW)
   ) u_rr_pick (
      .req   (i_m_cmd_valid),
      .ptr   (last_q),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign accept   = (state_q == VRB_ARB_IDLE) && pick_any;
   assign owner_oh = NM'(1) << owner_q;

`ifdef VRB_ARB_TIMEOUT_EN
   localparam int unsigned CW = 16;

   logic [CW-1:0] to_cnt_q, to_cnt_d;

   // Fires on the TO_CYCLES-th BUSY cycle without a response; a real response
   // in the same cycle takes precedence.
   assign timeout = (state_q == VRB_ARB_BUSY) && !i_s_rsp_valid &&
                    (to_cnt_q == CW'(TO_CYCLES - 1));

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (accept) begin
         to_cnt_d = '0;
      end else if ((state_q == VRB_ARB_BUSY) && !i_s_rsp_valid) begin
         to_cnt_d = to_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   logic unused_to_cycles;
   assign unused_to_cycles = ^TO_CYCLES;
   assign timeout          = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= VRB_ARB_IDLE;
         owner_q <= '0;
         last_q  <= IW'(NM - 1);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         VRB_ARB_IDLE: begin
            if (pick_any) begin
               state_d = VRB_ARB_BUSY;
               owner_d = pick_idx;
               last_d  = pick_idx;
            end
         end
         VRB_ARB_BUSY: begin
            if (i_s_rsp_valid || timeout) begin
               state_d = VRB_ARB_IDLE;
            end
         end
         default: state_d = VRB_ARB_IDLE;
      endcase
   end

   // Outputs; slave-side fields are zero when no command is presented, and a
   // response seen in IDLE is spurious and dropped.
   always_comb begin
      o_m_cmd_ready = '0;
      o_m_rsp_valid = '0;
      o_m_rsp_err   = 1'b0;
      o_m_rsp_rdata = '0;
      o_s_cmd_valid = 1'b0;
      o_s_cmd_addr  = '0;
      o_s_cmd_read  = 1'b0;
      o_s_cmd_wdata = '0;
      o_s_cmd_wmask = '0;
      if (accept) begin
         o_m_cmd_ready = pick_oh;
         o_s_cmd_valid = 1'b1;
         o_s_cmd_addr  = i_m_cmd_addr[32'(pick_idx)*AW +: AW];
         o_s_cmd_read  = i_m_cmd_read[pick_idx];
         o_s_cmd_wdata = i_m_cmd_wdata[32'(pick_idx)*DW +: DW];
         o_s_cmd_wmask = i_m_cmd_wmask[32'(pick_idx)*MW +: MW];
      end
      if (state_q == VRB_ARB_BUSY) begin
         if (i_s_rsp_valid) begin
            o_m_rsp_valid = owner_oh;
            o_m_rsp_err   = i_s_rsp_err;
            o_m_rsp_rdata = i_s_rsp_rdata;
         end else if (timeout) begin
            o_m_rsp_valid = owner_oh;
            o_m_rsp_err   = 1'b1;
         end
      end
   end

   assign o_busy = (state_q == VRB_ARB_BUSY);

endmodule

// File: doc/vrb_arbiter.md
Name: vrb_arbiter

Overview:
- Shares one VRB slave port (command/response bus) between NM masters, e.g. master 0 = instruction fetch, master 1 = LSU in exeu.
- Round-robin grant; at most one outstanding transaction; each response is routed back to the master that issued the command.
- Sits between the core's VRB masters and the memory/peripheral interconnect.

Parameters:
NM, 2, number of masters (2..8)
AW, 32, address width
DW, 32, data width; wmask width DW/8
TO_CYCLES, 255, watchdog limit in cycles; used only when VRB_ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_m_cmd_valid  input  NM  per-master command request
i_m_cmd_addr  input  NM*AW  per-master address; master k occupies slice [k*AW +: AW]
i_m_cmd_read  input  NM  1 = read, 0 = write
i_m_cmd_wdata  input  NM*DW  per-master write data
i_m_cmd_wmask  input  NM*DW/8  per-master byte mask
o_m_cmd_ready  output  NM  one-hot; command accepted this cycle
o_m_rsp_valid  output  NM  one-hot; response for master k
o_m_rsp_err  output  1  response error, shared by all masters
o_m_rsp_rdata  output  DW  response read data, shared by all masters
o_s_cmd_valid, o_s_cmd_addr, o_s_cmd_read, o_s_cmd_wdata, o_s_cmd_wmask  output  1/AW/1/DW/DW/8  slave command
i_s_rsp_valid, i_s_rsp_err, i_s_rsp_rdata  input  1/1/DW  slave response
o_busy  output  1  transaction outstanding

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one command issued; waiting for its response.
- IDLE:
  - If any i_m_cmd_valid is set, the winner is the first requesting master at or after (last_grant+1) mod NM.
  - The winner's fields drive o_s_cmd_* combinationally and o_s_cmd_valid=1 in the same cycle.
  - o_m_cmd_ready[winner]=1; owner<=winner; last_grant<=winner; next state BUSY.
  - Zero-cycle arbitration latency.
- BUSY:
  - o_s_cmd_valid=0 and all o_m_cmd_ready=0.
  - On i_s_rsp_valid: o_m_rsp_valid[owner]=1; err and rdata pass through combinationally; next state IDLE.
  - A new command is accepted no earlier than the following cycle, so the maximum rate is one transaction per 2 cycles.
- Slave timing: the slave samples a command whenever o_s_cmd_valid=1 and responds at least 1 cycle later.
- Response in IDLE: spurious; dropped, with all o_m_rsp_valid=0.
- Command fields are don't-care when the matching valid is 0. While valid is 1 and ready is 0, a master holds its command stable.
- o_busy=1 exactly in BUSY.
- Reset values:
  - state=IDLE; last_grant=NM-1, so master 0 has first priority.
  - owner=0; timeout counter=0.
  - All o_m_* and o_s_cmd_* outputs are 0.
- Reset mid-transaction: abandons the transaction. A late slave response after reset arrives in IDLE and is dropped.
- Wrap: last_grant=NM-1 wraps the search start to master 0.

Optional Feature:
VRB_ARB_TIMEOUT_EN
- Defined:
  - An 8..16-bit counter clears on entering BUSY and increments each BUSY cycle without i_s_rsp_valid.
  - When the counter reaches TO_CYCLES, the block returns o_m_rsp_valid[owner]=1, o_m_rsp_err=1, o_m_rsp_rdata=0, and goes to IDLE.
  - If the real response arrives in the same cycle as the timeout, the real response wins.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Package vrb_pkg holds:
  - state typedef (VRB_ARB_IDLE, VRB_ARB_BUSY);
  - localparam for grant index width, $clog2(NM) with minimum 1;
  - default TO_CYCLES.
- Sub-module rr_pick:
  - inputs: request vector and pointer;
  - outputs: one-hot grant and index;
  - purely combinational.
- The vrb_arbiter top holds all state.

Test Plan:
- Single master: m0 read addr 0x100, slave rsp 2 cycles later rdata 0xDEADBEEF -> ready[0] in cycle 0, o_m_rsp_valid=01, rdata 0xDEADBEEF, o_busy high for 2 cycles.
- Contention: m0 and m1 request continuously after reset -> grants m0, m1, m0, m1; each cmd address matches its master; no response misrouted.
- Write pass-through: m1 write addr 0x2000, wdata 0x12345678, wmask 4'b0011 -> slave sees the identical fields; rsp err=1 -> o_m_rsp_valid=10, o_m_rsp_err=1.
- Spurious response in IDLE, and reset asserted in BUSY with the rsp arriving after reset -> no o_m_rsp_valid pulse; state IDLE; next grant goes to m0.
- VRB_ARB_TIMEOUT_EN with TO_CYCLES=4: m0 read, slave silent -> after 4 BUSY cycles, o_m_rsp_valid=01, err=1, rdata=0; the next m1 request is granted the following cycle.
- Back-to-back stall: m0 holds valid while m1 owns the bus -> ready[0] stays 0 until the cycle after m1's response.
